vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//   640x480@60 Hz VGA timing generator, directly upstream of the paint stage.
//   Drives the raw hs/vs pixel counters that the paint stage uses for ROM/RAM addressing.
//   Drives the hsync_n/vsync_n/blank_n signals to the DAC, delayed to line up with
//   the paint stage's registered pixel output. Also provides frame_start and frame_cnt
//   for frame-level control (e.g. NPU result swap).
// PARAMETERS
//   H_VISIBLE 640 visible pixels/line;  H_FP 16 front porch;  H_SYNC 96 sync width;  H_BP 48 back porch
//   V_VISIBLE 480 visible lines;  V_FP 10;  V_SYNC 2;  V_BP 33
//   PIPE_DLY  2   sync/blank delay in clk_25 cycles, legal range 0..7
//   FCNT_W    16  frame_cnt width
// PORTS
//   clk_25      in   1       25 MHz pixel clock
//   rst         in   1       synchronous, active-high reset
//   hs          out  10      horizontal counter 0..H_TOTAL-1 (800); registered
//   vs          out  10      vertical counter 0..V_TOTAL-1 (525); registered
//   hsync_n     out  1       horizontal sync, active low, delayed PIPE_DLY
//   vsync_n     out  1       vertical sync, active low, delayed PIPE_DLY
//   blank_n     out  1       1 = visible area, delayed PIPE_DLY
//   frame_start out  1       1-cycle pulse coinciding with hs==0 && vs==0
//   frame_cnt   out  FCNT_W  completed-frame counter
// BEHAVIOUR
//   Counters:
//     hs increments every cycle and wraps H_TOTAL-1 -> 0.
//     vs increments only on an hs wrap and wraps V_TOTAL-1 -> 0.
//   Raw sync and blank, decoded from the registered hs/vs:
//     hsync_raw is 0 while hs is in [656,752).
//     vsync_raw is 0 while vs is in [490,492).
//     blank_raw is 1 while hs<640 and vs<480.
//   Delay: each raw signal passes through a PIPE_DLY-stage shift register.
//     With PIPE_DLY=0 the raw decode drives the output directly.
//   frame_start: register loaded with (hs==H_TOTAL-1 && vs==V_TOTAL-1).
//     It is therefore high exactly in the cycles where hs==0 && vs==0, except
//     the first cycle after reset release.
//   frame_cnt: increments in the same cycle frame_start rises; wraps from
//     2^FCNT_W-1 to 0.
//   Reset values:
//     hs=0, vs=0, frame_start=0, frame_cnt=0.
//     All delay stages clear to inactive (hsync_n=1, vsync_n=1, blank_n=0).
//   Reset mid-frame: counters return to 0 on the next edge. Outputs stay
//     inactive until real decode values propagate through the delay.
//     No partial sync pulse is stretched.
//   Period: one frame is 800*525 = 420000 cycles.
//     The first frame_start occurs 420000 cycles after rst deasserts.
// CONFIGURATION
//   VGA_TEST_PATTERN_EN defined:
//     Adds input tp_en (1 bit) and outputs tp_r, tp_g, tp_b (8 bits each).
//     Pattern is 8 vertical bars, bar index hs/80, colours in order:
//     white, yellow, cyan, green, magenta, red, blue, black.
//     Forced to 0 when blank_raw=0 or tp_en=0.
//     Registered, then delayed so total latency equals PIPE_DLY, aligned with hsync_n.
//     Reset value 0.
//   VGA_TEST_PATTERN_EN undefined: these ports and their logic do not exist.
// TESTING
//   Reset: rst high 3 cycles -> hs=0, vs=0, hsync_n=1, vsync_n=1, blank_n=0, frame_cnt=0, frame_start=0.
//   H timing, PIPE_DLY=2:
//     hsync_n falls in the cycle hs==658 and stays low exactly 96 cycles.
//     blank_n is high for 640 consecutive cycles per visible line, starting at hs==2.
//   V timing: vsync_n low for exactly 1600 cycles, starting at vs==490, hs==2.
//   Frame: run 3 frames -> frame_start pulses every 420000 cycles; frame_cnt reads 1, 2, 3.
//     Force FCNT_W=2 -> frame_cnt wraps 3 -> 0.
//   Mid-frame reset at hs=300, vs=200 -> next cycle hs=0, vs=0.
//     Delayed outputs read inactive for 2 cycles; frame_cnt=0.
//   VGA_TEST_PATTERN_EN, tp_en=1:
//     Raw hs=85, vs=10 -> 2 cycles later tp_r/g/b = FF/FF/00.
//     Raw hs=700 -> 0.
//     tp_en=0 -> 0 everywhere.

Source files
------------

// File: rtl/vga_sync_if.sv
// vga_sync_if: timing bundle between the VGA sync generator and its consumers
// (the paint stage and the DAC).
//   master modport : sync generator side (drives counters, syncs, frame info)
//   slave modport  : consumer side
//   hs, vs         : raw pixel/line counters (10 bits each)
//   hsync_n/vsync_n/blank_n : delayed DAC controls
//   frame_start, frame_cnt  : frame-level control
// Build option VGA_TEST_PATTERN_EN adds tp_en (consumer -> generator) and
// tp_r/tp_g/tp_b (generator -> consumer).
interface vga_sync_if #(
  parameter int FCNT_W = 16
);
  logic [9:0]        hs;
  logic [9:0]        vs;
  logic              hsync_n;
  logic              vsync_n;
  logic              blank_n;
  logic              frame_start;
  logic [FCNT_W-1:0] frame_cnt;
`ifdef VGA_TEST_PATTERN_EN
  logic              tp_en;
  logic [7:0]        tp_r;
  logic [7:0]        tp_g;
  logic [7:0]        tp_b;

  modport master (
    output hs, vs, hsync_n, vsync_n, blank_n, frame_start, frame_cnt,
    output tp_r, tp_g, tp_b,
    input  tp_en
  );
  modport slave (
    input  hs, vs, hsync_n, vsync_n, blank_n, frame_start, frame_cnt,
    input  tp_r, tp_g, tp_b,
    output tp_en
  );
`else
  modport master (
    output hs, vs, hsync_n, vsync_n, blank_n, frame_start, frame_cnt
  );
  modport slave (
    input  hs, vs, hsync_n, vsync_n, blank_n, frame_start, frame_cnt
  );
`endif
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 Hz VGA timing generator (timing is parameterised).
// Ports:
//   clk_25 : 25 MHz pixel clock
//   rst    : synchronous, active-high reset
//   vga    : vga_sync_if.master
//            hs/vs         raw counters, registered, used for ROM/RAM addressing
//            hsync_n/vsync_n/blank_n  decoded from hs/vs, delayed PIPE_DLY cycles
//                          to line up with the paint stage's registered pixel
//            frame_start   one-cycle pulse in the cycle hs==0 && vs==0
//            frame_cnt     completed-frame counter, wraps at 2^FCNT_W
// Build option VGA_TEST_PATTERN_EN: adds an 8-bar colour test pattern
// (tp_en in, tp_r/g/b out) that travels through the same delay line as the
// sync signals. Without the macro none of that logic exists.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int PIPE_DLY  = 2,
  parameter int FCNT_W    = 16
) (
  input  logic       clk_25,
  input  logic       rst,
  vga_sync_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  // Delay-line word: {[tp_r, tp_g, tp_b,] hsync_n, vsync_n, blank_n}.
  // Idle value has both syncs inactive (1) and blank asserted (0).
`ifdef VGA_TEST_PATTERN_EN
  localparam int SIG_W = 27;
`else
  localparam int SIG_W = 3;
`endif
  localparam logic [SIG_W-1:0] SIG_IDLE = SIG_W'(3'b110);

  logic [9:0]        hs_q, hs_d;
  logic [9:0]        vs_q, vs_d;
  logic              frame_start_q, frame_start_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic              hsync_raw;
  logic              vsync_raw;
  logic              blank_raw;
  logic [SIG_W-1:0]  sig_raw;
  logic [SIG_W-1:0]  sig_out;

  always_comb begin
    hs_d = hs_q + 10'd1;
    vs_d = vs_q;
    if (hs_q == H_LAST) begin
      hs_d = '0;
      vs_d = (vs_q == V_LAST) ? '0 : vs_q + 10'd1;
    end
    // Loaded on the last pixel of the frame so the pulse lands on hs==0,vs==0;
    // never set in the first cycle after reset since the counters were 0.
    frame_start_d = (hs_q == H_LAST) && (vs_q == V_LAST);
    frame_cnt_d   = frame_cnt_q;
    if (frame_start_d) begin
      frame_cnt_d = frame_cnt_q + FCNT_W'(1);
    end
  end

  always_ff @(posedge clk_25) begin
    if (rst) begin
      hs_q          <= '0;
      vs_q          <= '0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign hsync_raw = ~((hs_q >= HS_START) && (hs_q < HS_END));
  assign vsync_raw = ~((vs_q >= VS_START) && (vs_q < VS_END));
  assign blank_raw = (hs_q < H_VIS) && (vs_q < V_VIS);

`ifdef VGA_TEST_PATTERN_EN
  // Bars are 80 pixels wide. Colour order white, yellow, cyan, green,
  // magenta, red, blue, black maps onto the bar index bits as:
  // red off when bit1 set, green off when bit2 set, blue off when bit0 set.
  logic [2:0]  bar;
  logic [23:0] tp_rgb_raw;

  always_comb begin
    bar        = 3'(hs_q / 10'd80);
    tp_rgb_raw = '0;
    if (vga.tp_en && blank_raw) begin
      tp_rgb_raw[23:16] = {8{~bar[1]}};
      tp_rgb_raw[15:8]  = {8{~bar[2]}};
      tp_rgb_raw[7:0]   = {8{~bar[0]}};
    end
  end

  assign sig_raw = {tp_rgb_raw, hsync_raw, vsync_raw, blank_raw};
`else
  assign sig_raw = {hsync_raw, vsync_raw, blank_raw};
`endif

  // Reset clears every stage to idle, so a reset in the middle of a sync
  // pulse cuts it short instead of letting stale stages play out.
  if (PIPE_DLY == 0) begin : g_no_dly
    assign sig_out = sig_raw;
  end else begin : g_dly
    logic [SIG_W-1:0] pipe_q [PIPE_DLY];
    logic [SIG_W-1:0] pipe_d [PIPE_DLY];

    always_comb begin
      pipe_d[0] = sig_raw;
      for (int i = 1; i < PIPE_DLY; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end

    always_ff @(posedge clk_25) begin
      if (rst) begin
        for (int i = 0; i < PIPE_DLY; i++) begin
          pipe_q[i] <= SIG_IDLE;
        end
      end else begin
        for (int i = 0; i < PIPE_DLY; i++) begin
          pipe_q[i] <= pipe_d[i];
        end
      end
    end

    assign sig_out = pipe_q[PIPE_DLY-1];
  end

  assign vga.hs          = hs_q;
  assign vga.vs          = vs_q;
  assign vga.hsync_n     = sig_out[2];
  assign vga.vsync_n     = sig_out[1];
  assign vga.blank_n     = sig_out[0];
  assign vga.frame_start = frame_start_q;
  assign vga.frame_cnt   = frame_cnt_q;
`ifdef VGA_TEST_PATTERN_EN
  assign vga.tp_r = sig_out[26:19];
  assign vga.tp_g = sig_out[18:11];
  assign vga.tp_b = sig_out[10:3];
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: bench for vga_sync_gen.
// dut_a uses the real 640x480 timing (PIPE_DLY=2, FCNT_W=16) for line-level
// checks; dut_b uses a shrunken 30x19 raster with FCNT_W=2 so frames, vsync,
// frame_cnt wrap and mid-frame reset fit in a short run.
// The model derives every output from the number of clock edges since reset.
module tb_vga_sync_gen;

  typedef struct {
    longint hv, hfp, hsy, hbp, vv, vfp, vsy, vbp, pd, w;
  } tcfg_t;

  typedef struct {
    longint hs, vs, cnt, rgb;
    bit     hsn, vsn, bln, fs;
  } exp_t;

  tcfg_t cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 16};
  tcfg_t cfg_b = '{16, 4, 6, 4, 12, 2, 2, 3, 2, 2};

  logic [23:0] pal [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic   clk_25 = 1'b0;
  logic   rst_a, rst_b;
  longint ta = 0;
  longint tb_t = 0;
  bit     chk_en = 1'b0;
  int     checks = 0;
  int     errors = 0;
  exp_t   ea, eb;

  always #20 clk_25 = ~clk_25;

  vga_sync_if #(.FCNT_W(16)) if_a ();
  vga_sync_if #(.FCNT_W(2))  if_b ();

  vga_sync_gen #(.PIPE_DLY(2), .FCNT_W(16)) dut_a (
    .clk_25 (clk_25),
    .rst    (rst_a),
    .vga    (if_a)
  );

  vga_sync_gen #(
    .H_VISIBLE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .PIPE_DLY(2), .FCNT_W(2)
  ) dut_b (
    .clk_25 (clk_25),
    .rst    (rst_b),
    .vga    (if_b)
  );

  // Edge counts since the last edge that sampled reset.
  always @(posedge clk_25) begin
    ta   <= rst_a ? 0 : ta + 1;
    tb_t <= rst_b ? 0 : tb_t + 1;
  end

  function automatic exp_t model(input tcfg_t c, input longint t, input bit tp_on);
    exp_t   e;
    longint ht, vt, fr, td, h, v;
    ht    = c.hv + c.hfp + c.hsy + c.hbp;
    vt    = c.vv + c.vfp + c.vsy + c.vbp;
    fr    = ht * vt;
    e.hs  = t % ht;
    e.vs  = (t / ht) % vt;
    e.fs  = (t > 0) && (t % fr == 0);
    e.cnt = (t / fr) % (longint'(1) << c.w);
    e.hsn = 1'b1;
    e.vsn = 1'b1;
    e.bln = 1'b0;
    e.rgb = 0;
    if (t >= c.pd) begin
      td    = t - c.pd;
      h     = td % ht;
      v     = (td / ht) % vt;
      e.hsn = !(h >= c.hv + c.hfp && h < c.hv + c.hfp + c.hsy);
      e.vsn = !(v >= c.vv + c.vfp && v < c.vv + c.vfp + c.vsy);
      e.bln = (h < c.hv) && (v < c.vv);
      if (e.bln && tp_on) e.rgb = longint'(pal[int'(h / 80)]);
    end
    return e;
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e,
                           input logic [9:0] hs, input logic [9:0] vs,
                           input logic hsn, input logic vsn, input logic bln,
                           input logic fs, input logic [15:0] cnt);
    cmp({tag, "_hs"}, 64'(hs), e.hs);
    cmp({tag, "_vs"}, 64'(vs), e.vs);
    cmp({tag, "_hsync_n"}, 64'(hsn), 64'(e.hsn));
    cmp({tag, "_vsync_n"}, 64'(vsn), 64'(e.vsn));
    cmp({tag, "_blank_n"}, 64'(bln), 64'(e.bln));
    cmp({tag, "_frame_start"}, 64'(fs), 64'(e.fs));
    cmp({tag, "_frame_cnt"}, 64'(cnt), e.cnt);
  endtask

`ifdef VGA_TEST_PATTERN_EN
  logic tp_prev = 1'b0;
  int   tp_stable = 0;
  always @(posedge clk_25) begin
    if (if_a.tp_en === tp_prev) tp_stable <= tp_stable + 1;
    else tp_stable <= 0;
    tp_prev <= if_a.tp_en;
  end
`endif

  always @(negedge clk_25) begin
    if (chk_en) begin
`ifdef VGA_TEST_PATTERN_EN
      ea = model(cfg_a, ta, if_a.tp_en);
      if (tp_stable >= 3) cmp("a_tp_rgb", 64'({if_a.tp_r, if_a.tp_g, if_a.tp_b}), ea.rgb);
`else
      ea = model(cfg_a, ta, 1'b0);
`endif
      eb = model(cfg_b, tb_t, 1'b0);
      check_all("a", ea, if_a.hs, if_a.vs, if_a.hsync_n, if_a.vsync_n, if_a.blank_n,
                if_a.frame_start, if_a.frame_cnt);
      check_all("b", eb, if_b.hs, if_b.vs, if_b.hsync_n, if_b.vsync_n, if_b.blank_n,
                if_b.frame_start, 16'(if_b.frame_cnt));
    end
  end

  task automatic wait_t(input bit use_a, input longint k);
    int guard = 0;
    while ((use_a ? ta : tb_t) < k && guard < 20000) begin
      @(negedge clk_25);
      guard++;
    end
    checks++;
    if ((use_a ? ta : tb_t) != k) begin
      errors++;
      $display("FAIL wait_t: reached %0d wanted %0d", use_a ? ta : tb_t, k);
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
    if_a.tp_en = 1'b1;
    if_b.tp_en = 1'b0;
`endif
    repeat (3) @(negedge clk_25);
    chk_en = 1'b1;
    cmp("rst_hs_vs", 64'({if_a.hs, if_a.vs, if_b.hs, if_b.vs}), 64'd0);
    cmp("rst_sync_blank", 64'({if_a.hsync_n, if_a.vsync_n, if_a.blank_n,
                               if_b.hsync_n, if_b.vsync_n, if_b.blank_n}), 64'b110110);
    cmp("rst_frame", 64'({if_a.frame_start, if_a.frame_cnt, if_b.frame_start, if_b.frame_cnt}), 64'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    wait_t(1'b0, 2);
    cmp("lit_a_blank_first", 64'({if_a.hs, if_a.blank_n}), 64'({10'd2, 1'b1}));
    wait_t(1'b0, 421);  cmp("lit_b_vsync_before", 64'(if_b.vsync_n), 64'd1);
    wait_t(1'b0, 422);
    cmp("lit_b_vsync_fall", 64'({if_b.vs, if_b.hs, if_b.vsync_n}), 64'({10'd14, 10'd2, 1'b0}));
    wait_t(1'b0, 481);  cmp("lit_b_vsync_last", 64'(if_b.vsync_n), 64'd0);
    wait_t(1'b0, 482);  cmp("lit_b_vsync_end", 64'(if_b.vsync_n), 64'd1);
    wait_t(1'b0, 570);  cmp("lit_b_frame1", 64'({if_b.frame_start, if_b.frame_cnt}), 64'b101);
    wait_t(1'b0, 571);  cmp("lit_b_fs_drop", 64'(if_b.frame_start), 64'd0);
    wait_t(1'b0, 641);  cmp("lit_a_blank_last", 64'(if_a.blank_n), 64'd1);
    wait_t(1'b0, 642);  cmp("lit_a_blank_end", 64'(if_a.blank_n), 64'd0);
    wait_t(1'b0, 657);  cmp("lit_a_hsync_before", 64'(if_a.hsync_n), 64'd1);
    wait_t(1'b0, 658);
    cmp("lit_a_hsync_fall", 64'({if_a.hs, if_a.hsync_n}), 64'({10'd658, 1'b0}));
    wait_t(1'b0, 753);  cmp("lit_a_hsync_last", 64'(if_a.hsync_n), 64'd0);
    wait_t(1'b0, 754);  cmp("lit_a_hsync_end", 64'(if_a.hsync_n), 64'd1);
    wait_t(1'b0, 1140); cmp("lit_b_frame2", 64'(if_b.frame_cnt), 64'd2);
    wait_t(1'b0, 1710); cmp("lit_b_frame3", 64'(if_b.frame_cnt), 64'd3);
    wait_t(1'b0, 2280); cmp("lit_b_cnt_wrap", 64'({if_b.frame_start, if_b.frame_cnt}), 64'b100);

    // Mid-frame reset on dut_b while its vsync_n is low.
    wait_t(1'b0, 2720);
    cmp("lit_b_pre_rst", 64'({if_b.vs, if_b.hs, if_b.vsync_n}), 64'({10'd14, 10'd20, 1'b0}));
    rst_b = 1'b1;
    @(negedge clk_25);
    cmp("lit_b_rst_cnt", 64'({if_b.hs, if_b.vs, if_b.frame_cnt, if_b.frame_start}), 64'd0);
    cmp("lit_b_rst_out0", 64'({if_b.hsync_n, if_b.vsync_n, if_b.blank_n}), 64'b110);
    rst_b = 1'b0;
    @(negedge clk_25);
    cmp("lit_b_rst_out1", 64'({if_b.hs, if_b.hsync_n, if_b.vsync_n, if_b.blank_n}),
        64'({10'd1, 3'b110}));
    @(negedge clk_25);
    cmp("lit_b_rst_out2", 64'({if_b.hsync_n, if_b.vsync_n, if_b.blank_n}), 64'b111);

`ifdef VGA_TEST_PATTERN_EN
    wait_t(1'b1, 8087);
    cmp("lit_a_tp_yellow", 64'({if_a.tp_r, if_a.tp_g, if_a.tp_b}), 64'hFFFF00);
    wait_t(1'b1, 8702);
    cmp("lit_a_tp_porch", 64'({if_a.tp_r, if_a.tp_g, if_a.tp_b}), 64'h0);
    wait_t(1'b1, 9000);
    if_a.tp_en = 1'b0;
    wait_t(1'b1, 9100);
    cmp("lit_a_tp_off", 64'({if_a.tp_r, if_a.tp_g, if_a.tp_b}), 64'h0);
`endif
    wait_t(1'b1, 10000);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
